// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle for digit_serial_adder.
// The sub select exists only when SUB_MODE_EN is defined.
interface digit_serial_adder_if #(
   parameter int unsigned SIZE = 16
);
   logic            in_valid;
   logic            in_ready;
   logic [SIZE-1:0] A;
   logic [SIZE-1:0] B;
   logic            Cin;
`ifdef SUB_MODE_EN
   logic            sub;
`endif
   logic            out_valid;
   logic            out_ready;
   logic [SIZE-1:0] S;
   logic            Cout;
   logic            ovf;

   // Producer of operands / consumer of results
   modport master (
      input  in_ready, out_valid, S, Cout, ovf,
`ifdef SUB_MODE_EN
      output sub,
`endif
      output in_valid, A, B, Cin, out_ready
   );

   // The adder itself
   modport slave (
      output in_ready, out_valid, S, Cout, ovf,
`ifdef SUB_MODE_EN
      input  sub,
`endif
      input  in_valid, A, B, Cin, out_ready
   );
endinterface

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds two SIZE-bit operands DIGIT bits per clock through a
// registered carry, with valid/ready handshakes and signed-overflow reporting.
// Optional subtract mode is enabled by defining SUB_MODE_EN.
module digit_serial_adder #(
   parameter int unsigned SIZE  = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   digit_serial_adder_if.slave  bus
);
   localparam int unsigned NDIG = SIZE / DIGIT;
   localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state;
   logic [SIZE-1:0] a_q;
   logic [SIZE-1:0] b_q;
   logic [SIZE-1:0] s_q;
   logic            carry_q;
   logic            sub_q;
   logic [CW-1:0]   cnt_q;
   logic            cout_q;
   logic            ovf_q;
   logic            in_ready_q;
   logic            out_valid_q;

   logic            sub_in;
   logic [DIGIT-1:0] a_dig;
   logic [DIGIT-1:0] b_raw;
   logic [DIGIT-1:0] b_dig;
   logic [DIGIT:0]   dsum;
   logic             c_msb;
   logic [SIZE-1:0]  s_nxt;

`ifdef SUB_MODE_EN
   assign sub_in = bus.sub;
`else
   assign sub_in = 1'b0;
`endif

   // Select the current digit of each operand and merge the digit sum into S
   if (NDIG == 1) begin : g_single
      assign a_dig = a_q;
      assign b_raw = b_q;
      always_comb begin
         s_nxt = dsum[DIGIT-1:0];
      end
   end else begin : g_multi
      localparam int unsigned IW = $clog2(SIZE);
      logic [IW-1:0] base;
      assign base  = IW'(cnt_q * DIGIT);
      assign a_dig = a_q[base +: DIGIT];
      assign b_raw = b_q[base +: DIGIT];
      always_comb begin
         s_nxt = s_q;
         s_nxt[base +: DIGIT] = dsum[DIGIT-1:0];
      end
   end

   // One digit of addition; carry into the digit MSB recovered from its sum bit
   always_comb begin
      b_dig = b_raw ^ {DIGIT{sub_q}};
      dsum  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
      c_msb = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dsum[DIGIT-1];
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         s_q         <= '0;
         carry_q     <= 1'b0;
         sub_q       <= 1'b0;
         cnt_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q        <= bus.A;
                  b_q        <= bus.B;
                  sub_q      <= sub_in;
                  // subtract: A + ~B + ~Cin, so a borrow-in clears the initial carry
                  carry_q    <= bus.Cin ^ sub_in;
                  s_q        <= '0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               s_q     <= s_nxt;
               carry_q <= dsum[DIGIT];
               if (cnt_q == LAST) begin
                  cout_q      <= dsum[DIGIT];
                  ovf_q       <= c_msb ^ dsum[DIGIT];
                  cnt_q       <= '0;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.S         = s_q;
   assign bus.Cout      = cout_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: three instances (DIGIT 4, 16, 1) share one
// stimulus stream; a spec-level model predicts handshake timing and results.
`timescale 1ns/1ps
module tb_digit_serial_adder;
   localparam int unsigned SIZE = 16;
   localparam int NDUT = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic [SIZE-1:0] a_d;
   logic [SIZE-1:0] b_d;
   logic            cin_d;
   logic            sub_d;
   logic            out_ready;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   digit_serial_adder_if #(.SIZE(SIZE)) bus0 ();
   digit_serial_adder_if #(.SIZE(SIZE)) bus1 ();
   digit_serial_adder_if #(.SIZE(SIZE)) bus2 ();

   assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;  assign bus2.in_valid = in_valid;
   assign bus0.A = a_d;              assign bus1.A = a_d;              assign bus2.A = a_d;
   assign bus0.B = b_d;              assign bus1.B = b_d;              assign bus2.B = b_d;
   assign bus0.Cin = cin_d;          assign bus1.Cin = cin_d;          assign bus2.Cin = cin_d;
   assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready; assign bus2.out_ready = out_ready;
`ifdef SUB_MODE_EN
   assign bus0.sub = sub_d;          assign bus1.sub = sub_d;          assign bus2.sub = sub_d;
`endif

   digit_serial_adder #(.SIZE(SIZE), .DIGIT(4))  u_d4  (.clk(clk), .rst(rst), .bus(bus0.slave));
   digit_serial_adder #(.SIZE(SIZE), .DIGIT(16)) u_d16 (.clk(clk), .rst(rst), .bus(bus1.slave));
   digit_serial_adder #(.SIZE(SIZE), .DIGIT(1))  u_d1  (.clk(clk), .rst(rst), .bus(bus2.slave));

   logic [SIZE-1:0] o_s  [NDUT];
   logic            o_c  [NDUT];
   logic            o_o  [NDUT];
   logic            o_ir [NDUT];
   logic            o_ov [NDUT];
   assign o_s[0] = bus0.S;    assign o_s[1] = bus1.S;    assign o_s[2] = bus2.S;
   assign o_c[0] = bus0.Cout; assign o_c[1] = bus1.Cout; assign o_c[2] = bus2.Cout;
   assign o_o[0] = bus0.ovf;  assign o_o[1] = bus1.ovf;  assign o_o[2] = bus2.ovf;
   assign o_ir[0] = bus0.in_ready;  assign o_ir[1] = bus1.in_ready;  assign o_ir[2] = bus2.in_ready;
   assign o_ov[0] = bus0.out_valid; assign o_ov[1] = bus1.out_valid; assign o_ov[2] = bus2.out_valid;

   function automatic int ndig(input int i);
      return (i == 0) ? 4 : ((i == 1) ? 1 : 16);
   endfunction

   // Spec arithmetic: {ovf, Cout, S} from plain integer math
   function automatic logic [SIZE+1:0] calc(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                            input logic cin, input logic sb);
      int ua, ub, sa, sbb, ur, sr;
      logic v, c;
      ua  = int'(a);
      ub  = int'(b);
      sa  = int'($signed(a));
      sbb = int'($signed(b));
      if (sb) begin
         ur = ua - ub - int'(cin);
         sr = sa - sbb - int'(cin);
         c  = (ur >= 0);
      end else begin
         ur = ua + ub + int'(cin);
         sr = sa + sbb + int'(cin);
         c  = (ur > 65535);
      end
      v = (sr > 32767) || (sr < -32768);
      return {v, c, ur[15:0]};
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, idx, act, exp, $time);
      end
   endtask

   // Model: phase 0 idle, 1 busy, 2 done
   int              ph   [NDUT];
   int              rem  [NDUT];
   logic [SIZE-1:0] es   [NDUT];
   logic            ec   [NDUT];
   logic            eo   [NDUT];
   logic [SIZE-1:0] ps   [NDUT];
   logic            pc   [NDUT];
   logic            po   [NDUT];
   bit              s_known [NDUT];

   always @(posedge clk) begin
      for (int i = 0; i < NDUT; i++) begin
         if (rst) begin
            ph[i] <= 0; es[i] <= '0; ec[i] <= 1'b0; eo[i] <= 1'b0; s_known[i] <= 1'b1;
         end else begin
            case (ph[i])
               0: if (in_valid) begin
                  {po[i], pc[i], ps[i]} <= calc(a_d, b_d, cin_d, sub_d);
                  rem[i] <= ndig(i);
                  ph[i] <= 1;
                  s_known[i] <= 1'b0;
               end
               1: if (rem[i] == 1) begin
                  ph[i] <= 2; es[i] <= ps[i]; ec[i] <= pc[i]; eo[i] <= po[i]; s_known[i] <= 1'b1;
               end else begin
                  rem[i] <= rem[i] - 1;
               end
               default: if (out_ready) begin
                  ph[i] <= 0; s_known[i] <= 1'b0;
               end
            endcase
         end
      end
   end

   // Per-cycle compare against the model; also latch last presented result
   int              got_cnt [NDUT];
   logic [SIZE-1:0] gs [NDUT];
   logic            gc [NDUT];
   logic            go [NDUT];
   initial for (int i = 0; i < NDUT; i++) got_cnt[i] = 0;

   always @(negedge clk) begin
      for (int i = 0; i < NDUT; i++) begin
         chk("in_ready",  i, 32'(o_ir[i]), 32'(ph[i] == 0));
         chk("out_valid", i, 32'(o_ov[i]), 32'(ph[i] == 2));
         chk("Cout",      i, 32'(o_c[i]),  32'(ec[i]));
         chk("ovf",       i, 32'(o_o[i]),  32'(eo[i]));
         if (s_known[i]) chk("S", i, 32'(o_s[i]), 32'(es[i]));
         if (o_ov[i] === 1'b1) begin
            got_cnt[i] <= got_cnt[i] + 1;
            gs[i] <= o_s[i]; gc[i] <= o_c[i]; go[i] <= o_o[i];
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!(ph[0] == 0 && ph[1] == 0 && ph[2] == 0) && n < 200) begin
         @(posedge clk); #1; n++;
      end
      chk("idle_timeout", 0, 32'(n >= 200), 32'(0));
   endtask

   task automatic wait_got(input int s0, input int s1, input int s2);
      int n = 0;
      while ((got_cnt[0] == s0 || got_cnt[1] == s1 || got_cnt[2] == s2) && n < 200) begin
         @(posedge clk); #1; n++;
      end
      chk("result_timeout", 0, 32'(n >= 200), 32'(0));
   endtask

   task automatic lit(input string nm, input logic [SIZE-1:0] s, input logic c, input logic v);
      for (int i = 0; i < NDUT; i++) begin
         chk({nm, "_S"},    i, 32'(gs[i]), 32'(s));
         chk({nm, "_Cout"}, i, 32'(gc[i]), 32'(c));
         chk({nm, "_ovf"},  i, 32'(go[i]), 32'(v));
      end
   endtask

   task automatic run_op(input string nm, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                         input logic cin, input logic sb,
                         input logic [SIZE-1:0] xs, input logic xc, input logic xv);
      int s0, s1, s2;
      wait_idle();
      s0 = got_cnt[0]; s1 = got_cnt[1]; s2 = got_cnt[2];
      in_valid = 1'b1; a_d = a; b_d = b; cin_d = cin; sub_d = sb;
      @(posedge clk); #1;
      in_valid = 1'b0; a_d = '0; b_d = '0; cin_d = 1'b0;
      wait_got(s0, s1, s2);
      lit(nm, xs, xc, xv);
      sub_d = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [SIZE+1:0] r;
      int s0, s1, s2, n;
      rst = 1'b1; in_valid = 1'b0; a_d = '0; b_d = '0; cin_d = 1'b0; sub_d = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < NDUT; i++) begin
         chk("rst_S",         i, 32'(o_s[i]),  32'h0);
         chk("rst_Cout",      i, 32'(o_c[i]),  32'h0);
         chk("rst_ovf",       i, 32'(o_o[i]),  32'h0);
         chk("rst_out_valid", i, 32'(o_ov[i]), 32'h0);
         chk("rst_in_ready",  i, 32'(o_ir[i]), 32'h1);
      end
      rst = 1'b0;

      // Pin the model arithmetic to hand-computed values
      r = calc(16'h1234, 16'h4321, 1'b0, 1'b0); chk("model_add",  0, 32'(r), 32'h05555);
      r = calc(16'h7FFF, 16'h0001, 1'b0, 1'b0); chk("model_ovf",  0, 32'(r), 32'h28000);
      r = calc(16'hFFFF, 16'h0001, 1'b0, 1'b0); chk("model_cout", 0, 32'(r), 32'h10000);
      r = calc(16'h0005, 16'h0007, 1'b0, 1'b1); chk("model_sub",  0, 32'(r), 32'h0FFFE);
      r = calc(16'h8000, 16'h0001, 1'b0, 1'b1); chk("model_subv", 0, 32'(r), 32'h37FFF);

      run_op("basic",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("cin",    16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
      run_op("negovf", 16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);

      // Backpressure with new operands offered throughout DONE
      wait_idle();
      out_ready = 1'b0;
      in_valid = 1'b1; a_d = 16'h8000; b_d = 16'h8000; cin_d = 1'b0;
      @(posedge clk); #1;
      a_d = 16'h0001; b_d = 16'h0001;
      n = 0;
      while (!(ph[0] == 2 && ph[1] == 2 && ph[2] == 2) && n < 200) begin
         @(posedge clk); #1; n++;
      end
      chk("bp_timeout", 0, 32'(n >= 200), 32'(0));
      repeat (5) @(posedge clk);
      #1;
      lit("bp_hold", 16'h0000, 1'b1, 1'b1);
      for (int i = 0; i < NDUT; i++) chk("bp_in_ready", i, 32'(o_ir[i]), 32'h0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      s0 = got_cnt[0]; s1 = got_cnt[1]; s2 = got_cnt[2];
      @(posedge clk); #1;
      in_valid = 1'b0; a_d = '0; b_d = '0;
      wait_got(s0, s1, s2);
      lit("bp_next", 16'h0002, 1'b0, 1'b0);

      // Reset during the third BUSY cycle of the DIGIT=4 instance
      wait_idle();
      s0 = got_cnt[0]; s2 = got_cnt[2];
      in_valid = 1'b1; a_d = 16'hAAAA; b_d = 16'h5555;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < NDUT; i++) begin
         chk("midrst_out_valid", i, 32'(o_ov[i]), 32'h0);
         chk("midrst_in_ready",  i, 32'(o_ir[i]), 32'h1);
         chk("midrst_S",         i, 32'(o_s[i]),  32'h0);
         chk("midrst_Cout",      i, 32'(o_c[i]),  32'h0);
      end
      repeat (20) @(posedge clk);
      #1;
      chk("midrst_no_result", 0, 32'(got_cnt[0] - s0), 32'h0);
      chk("midrst_no_result", 2, 32'(got_cnt[2] - s2), 32'h0);

      run_op("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

`ifdef SUB_MODE_EN
      run_op("sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_op("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_op("sub_bin",  16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFE, 1'b1, 1'b0);
`endif

      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
